// File: rtl/std_invoke.sv
// Initiator that issues valid/ready requests to a callee primitive and folds each
// callee result back as the next left operand. A hung callee is caught by a timeout.
module std_invoke #(
    parameter int width     = 32,
    parameter int cnt_width = 8,
    parameter int timeout   = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 go,
    input  logic [cnt_width-1:0] iters,
    input  logic [width-1:0]     left_in,
    input  logic [width-1:0]     right_in,
    output logic                 busy,
    output logic                 done,
    output logic                 timed_out,
    output logic [width-1:0]     result,
    output logic                 callee_valid,
    output logic                 callee_reset,
    output logic [width-1:0]     callee_left,
    output logic [width-1:0]     callee_right,
    input  logic                 callee_ready,
    input  logic [width-1:0]     callee_out
);

    localparam int WAIT_W = $clog2(timeout + 1);
    // Value of the wait counter during the last ISSUE cycle before giving up.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(timeout - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_GAP   = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    logic [2:0]           state_q, state_d;
    logic [width-1:0]     acc_q, acc_d;
    logic [width-1:0]     rhs_q, rhs_d;
    logic [width-1:0]     result_q, result_d;
    logic [cnt_width-1:0] rem_q, rem_d;
    logic [WAIT_W-1:0]    wait_q, wait_d;
    logic                 timed_out_q, timed_out_d;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        rhs_d       = rhs_q;
        result_d    = result_q;
        rem_d       = rem_q;
        wait_d      = wait_q;
        timed_out_d = timed_out_q;
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    acc_d       = left_in;
                    result_d    = left_in;
                    rhs_d       = right_in;
                    rem_d       = iters;
                    wait_d      = '0;
                    timed_out_d = 1'b0;
                    state_d     = (iters == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                // A response in the final allowed cycle still counts: ready wins over timeout.
                if (callee_ready) begin
                    acc_d    = callee_out;
                    result_d = callee_out;
                    rem_d    = rem_q - 1'b1;
                    wait_d   = '0;
                    state_d  = (rem_q == cnt_width'(1)) ? S_DONE : S_GAP;
                end else begin
                    wait_d = wait_q + 1'b1;
                    if (wait_q == WAIT_LAST) begin
                        state_d = S_ERR;
                    end
                end
            end
            S_GAP:   state_d = S_ISSUE;
            S_DONE:  state_d = S_IDLE;
            S_ERR: begin
                timed_out_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            rhs_q       <= '0;
            result_q    <= '0;
            rem_q       <= '0;
            wait_q      <= '0;
            timed_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            rhs_q       <= rhs_d;
            result_q    <= result_d;
            rem_q       <= rem_d;
            wait_q      <= wait_d;
            timed_out_q <= timed_out_d;
        end
    end

    // All outputs decode from registered state, so reset clears them immediately.
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE) || (state_q == S_ERR);
    assign callee_valid = (state_q == S_ISSUE);
    assign callee_reset = (state_q == S_ERR);
    assign callee_left  = acc_q;
    assign callee_right = rhs_q;
    assign result       = result_q;
    assign timed_out    = timed_out_q;

endmodule

// File: tb/tb_std_invoke.sv
// Bench for std_invoke: a reactive callee with programmable per-request delays,
// checked against a fold-level reference model of result, timing and errors.
module tb_std_invoke;
    localparam int W   = 16;
    localparam int CW  = 8;
    localparam int TMO = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          go;
    logic [CW-1:0] iters;
    logic [W-1:0]  left_in, right_in;
    logic          busy, done, timed_out, callee_valid, callee_reset, callee_ready;
    logic [W-1:0]  result, callee_left, callee_right, callee_out;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    std_invoke #(.width(W), .cnt_width(CW), .timeout(TMO)) dut (
        .clk(clk), .reset(rst_n), .go(go), .iters(iters),
        .left_in(left_in), .right_in(right_in),
        .busy(busy), .done(done), .timed_out(timed_out), .result(result),
        .callee_valid(callee_valid), .callee_reset(callee_reset),
        .callee_left(callee_left), .callee_right(callee_right),
        .callee_ready(callee_ready), .callee_out(callee_out)
    );

    // Callee: request i is answered after delays[i] un-ready ISSUE cycles.
    int           delays[16];
    int           cidx, cwait;
    bit           op_mul, noise_en;
    logic [W-1:0] junk;

    always @(negedge clk) begin
        junk = W'($urandom);
        if (!rst_n) begin
            callee_ready = 1'b0;
        end else if (callee_valid) begin
            if (cidx > 15 || cwait >= delays[cidx]) begin
                callee_ready = 1'b1;
                cidx++;
                cwait = 0;
            end else begin
                callee_ready = 1'b0;
                cwait++;
            end
        end else begin
            callee_ready = noise_en ? 1'($urandom) : 1'b0;
        end
    end

    assign callee_out = callee_ready ? (op_mul ? W'(callee_left * callee_right)
                                               : W'(callee_left + callee_right)) : junk;

    // Observations from one transaction.
    int           obs_cyc, obs_done_cnt, obs_rst_cnt, obs_valid_cnt, obs_busy_gap;
    logic         obs_to_pre, obs_to_c1, obs_to_after, obs_busy_after;
    logic [W-1:0] obs_result;
    // Reference-model expectations.
    logic [W-1:0] exp_result;
    int           exp_cyc, exp_valid;
    bit           exp_err;

    task automatic set_delays(input int d);
        for (int i = 0; i < 16; i++) delays[i] = d;
    endtask

    task automatic model(input logic [W-1:0] l, input logic [W-1:0] r, input int n, input bit mul);
        logic [W-1:0] acc;
        int t;
        acc = l; t = 0;
        exp_err = 0; exp_valid = 0; exp_cyc = (n == 0) ? 1 : 0;
        for (int i = 0; i < n; i++) begin
            if (delays[i] >= TMO) begin
                exp_err = 1; exp_valid += TMO; exp_cyc = 1 + t + TMO;
                break;
            end
            acc = mul ? W'(acc * r) : W'(acc + r);
            t += delays[i] + 2;
            exp_valid += delays[i] + 1;
            exp_cyc = t;
        end
        exp_result = acc;
    endtask

    // Cycle 1 is the cycle after the edge that samples go.
    task automatic run_txn(input logic [W-1:0] l, input logic [W-1:0] r, input int n,
                           input bit mul, input bit busy_go);
        int c;
        @(negedge clk);
        op_mul = mul; cidx = 0; cwait = 0;
        obs_to_pre = timed_out;
        left_in = l; right_in = r; iters = CW'(n); go = 1'b1;
        @(negedge clk);
        go = 1'b0; left_in = W'($urandom); right_in = W'($urandom); iters = CW'($urandom);
        obs_to_c1 = timed_out;
        obs_cyc = -1; obs_done_cnt = 0; obs_rst_cnt = 0; obs_valid_cnt = 0; obs_busy_gap = 0;
        obs_busy_after = 1'bx; obs_to_after = 1'bx; obs_result = 'x;
        c = 1;
        while (c <= 400) begin
            if (done) begin
                obs_done_cnt++;
                if (obs_cyc < 0) obs_cyc = c;
            end
            if (callee_reset) obs_rst_cnt++;
            if (callee_valid) obs_valid_cnt++;
            if (obs_cyc < 0 && !busy) obs_busy_gap++;
            if (obs_cyc >= 0 && c == obs_cyc + 1) begin
                obs_busy_after = busy; obs_to_after = timed_out; obs_result = result;
                break;
            end
            go = busy_go && obs_cyc < 0 && ($urandom_range(0, 3) == 0);
            if (go) begin
                left_in = W'($urandom); right_in = W'($urandom); iters = CW'($urandom_range(0, 3));
            end
            c++;
            @(negedge clk);
        end
        go = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; go = 1'b0; iters = CW'($urandom);
        left_in = W'($urandom); right_in = W'($urandom);
        repeat (3) @(negedge clk);
        n_cmp++; if ({busy, done, timed_out, callee_valid, callee_reset} !== 5'b0) begin
            n_bad++; $display("FAIL reset_flags: got %b want 00000", {busy, done, timed_out, callee_valid, callee_reset}); end
        n_cmp++; if ({result, callee_left, callee_right} !== '0) begin
            n_bad++; $display("FAIL reset_data: got %h/%h/%h want 0", result, callee_left, callee_right); end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
        $display("txn reset: busy=%b result=%h", busy, result);
    endtask

    task automatic test_add_fold();
        set_delays(0);
        run_txn(16'd5, 16'd3, 4, 1'b0, 1'b0);
        n_cmp++; if (obs_result !== 16'd17) begin n_bad++; $display("FAIL add_result: got %0d want 17", obs_result); end
        n_cmp++; if (obs_cyc !== 8) begin n_bad++; $display("FAIL add_done_cycle: got %0d want 8", obs_cyc); end
        n_cmp++; if (obs_valid_cnt !== 4) begin n_bad++; $display("FAIL add_valid_cycles: got %0d want 4", obs_valid_cnt); end
        n_cmp++; if (obs_done_cnt !== 1) begin n_bad++; $display("FAIL add_done_pulses: got %0d want 1", obs_done_cnt); end
        n_cmp++; if (obs_to_after !== 1'b0 || obs_busy_after !== 1'b0) begin
            n_bad++; $display("FAIL add_after: got to=%b busy=%b want 0 0", obs_to_after, obs_busy_after); end
        $display("txn add: result=%0d done_cycle=%0d", obs_result, obs_cyc);
    endtask

    task automatic test_mul_overflow();
        set_delays(0);
        run_txn(16'd2, 16'd256, 2, 1'b1, 1'b0);
        n_cmp++; if (obs_result !== 16'd0) begin n_bad++; $display("FAIL mul_result: got %0d want 0", obs_result); end
        n_cmp++; if (obs_cyc !== 4) begin n_bad++; $display("FAIL mul_done_cycle: got %0d want 4", obs_cyc); end
        $display("txn mul: result=%0d done_cycle=%0d", obs_result, obs_cyc);
    endtask

    task automatic test_zero_iters();
        set_delays(0);
        run_txn(16'hDEAD, 16'd7, 0, 1'b0, 1'b0);
        n_cmp++; if (obs_result !== 16'hDEAD) begin n_bad++; $display("FAIL zero_result: got %h want dead", obs_result); end
        n_cmp++; if (obs_cyc !== 1) begin n_bad++; $display("FAIL zero_done_cycle: got %0d want 1", obs_cyc); end
        n_cmp++; if (obs_valid_cnt !== 0) begin n_bad++; $display("FAIL zero_valid: got %0d want 0", obs_valid_cnt); end
        $display("txn zero: result=%h done_cycle=%0d", obs_result, obs_cyc);
    endtask

    task automatic test_timeout();
        set_delays(100);
        run_txn(16'h1234, 16'd5, 3, 1'b0, 1'b0);
        n_cmp++; if (obs_cyc !== TMO + 1) begin n_bad++; $display("FAIL tmo_done_cycle: got %0d want %0d", obs_cyc, TMO + 1); end
        n_cmp++; if (obs_valid_cnt !== TMO) begin n_bad++; $display("FAIL tmo_valid: got %0d want %0d", obs_valid_cnt, TMO); end
        n_cmp++; if (obs_rst_cnt !== 1 || obs_done_cnt !== 1) begin
            n_bad++; $display("FAIL tmo_pulses: got rst=%0d done=%0d want 1 1", obs_rst_cnt, obs_done_cnt); end
        n_cmp++; if (obs_to_after !== 1'b1) begin n_bad++; $display("FAIL tmo_flag: got %b want 1", obs_to_after); end
        n_cmp++; if (obs_result !== 16'h1234) begin n_bad++; $display("FAIL tmo_result: got %h want 1234", obs_result); end
        $display("txn timeout: done_cycle=%0d timed_out=%b", obs_cyc, obs_to_after);
        repeat (3) @(negedge clk);
        set_delays(0);
        run_txn(16'd1, 16'd1, 1, 1'b0, 1'b0);
        n_cmp++; if (obs_to_pre !== 1'b1) begin n_bad++; $display("FAIL tmo_sticky: got %b want 1", obs_to_pre); end
        n_cmp++; if (obs_to_c1 !== 1'b0 || obs_to_after !== 1'b0) begin
            n_bad++; $display("FAIL tmo_clear: got c1=%b after=%b want 0 0", obs_to_c1, obs_to_after); end
        n_cmp++; if (obs_result !== 16'd2) begin n_bad++; $display("FAIL tmo_recover_result: got %0d want 2", obs_result); end
        $display("txn recover: result=%0d timed_out=%b", obs_result, obs_to_after);
    endtask

    task automatic test_slow_boundary();
        set_delays(TMO - 1);
        run_txn(16'd100, 16'd7, 2, 1'b0, 1'b1);
        n_cmp++; if (obs_rst_cnt !== 0 || obs_to_after !== 1'b0) begin
            n_bad++; $display("FAIL slow_error: got rst=%0d to=%b want 0 0", obs_rst_cnt, obs_to_after); end
        n_cmp++; if (obs_result !== 16'd114) begin n_bad++; $display("FAIL slow_result: got %0d want 114", obs_result); end
        n_cmp++; if (obs_cyc !== 2 * (TMO + 1)) begin n_bad++; $display("FAIL slow_done_cycle: got %0d want %0d", obs_cyc, 2 * (TMO + 1)); end
        n_cmp++; if (obs_busy_gap !== 0 || obs_busy_after !== 1'b0) begin
            n_bad++; $display("FAIL slow_busy: got gaps=%0d after=%b want 0 0", obs_busy_gap, obs_busy_after); end
        $display("txn slow: result=%0d done_cycle=%0d", obs_result, obs_cyc);
    endtask

    task automatic test_reset_mid_op();
        int seen, c, dn;
        set_delays(0);
        @(negedge clk);
        op_mul = 1'b0; cidx = 0; cwait = 0;
        left_in = 16'd10; right_in = 16'd1; iters = CW'(4); go = 1'b1;
        @(negedge clk);
        go = 1'b0; seen = 0; c = 1;
        while (c < 20) begin
            if (callee_valid) seen++;
            if (seen == 2) break;
            c++;
            @(negedge clk);
        end
        n_cmp++; if (seen !== 2) begin n_bad++; $display("FAIL midrst_second_issue: got %0d issues want 2", seen); end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if ({busy, done, timed_out, callee_valid, callee_reset} !== 5'b0 || {result, callee_left, callee_right} !== '0) begin
            n_bad++; $display("FAIL midrst_outputs: got flags=%b result=%h want 0", {busy, done, timed_out, callee_valid, callee_reset}, result); end
        dn = 0;
        repeat (3) begin @(negedge clk); if (done) dn++; end
        n_cmp++; if (dn !== 0) begin n_bad++; $display("FAIL midrst_done: got %0d pulses want 0", dn); end
        rst_n = 1'b1;
        run_txn(16'd10, 16'd1, 4, 1'b0, 1'b0);
        n_cmp++; if (obs_result !== 16'd14 || obs_cyc !== 8) begin
            n_bad++; $display("FAIL midrst_fresh: got result=%0d cycle=%0d want 14 8", obs_result, obs_cyc); end
        $display("txn reset_mid_op: fresh result=%0d done_cycle=%0d", obs_result, obs_cyc);
    endtask

    task automatic test_random();
        logic [W-1:0] l, r;
        int n, rr;
        bit mul, bg;
        noise_en = 1'b1;
        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < 16; i++) begin
                rr = $urandom_range(0, 19);
                delays[i] = (rr < 2) ? TMO + rr * 3 : (rr < 5) ? TMO - 1 : $urandom_range(0, 3);
            end
            mul = 1'($urandom); bg = 1'($urandom);
            n = $urandom_range(0, 6);
            l = W'($urandom);
            r = mul ? W'($urandom_range(0, 9)) : W'($urandom);
            model(l, r, n, mul);
            run_txn(l, r, n, mul, bg);
            n_cmp++; if (obs_result !== exp_result) begin n_bad++; $display("FAIL rnd_result[%0d]: got %h want %h", k, obs_result, exp_result); end
            n_cmp++; if (obs_cyc !== exp_cyc) begin n_bad++; $display("FAIL rnd_done_cycle[%0d]: got %0d want %0d", k, obs_cyc, exp_cyc); end
            n_cmp++; if (obs_valid_cnt !== exp_valid) begin n_bad++; $display("FAIL rnd_valid[%0d]: got %0d want %0d", k, obs_valid_cnt, exp_valid); end
            n_cmp++; if (obs_rst_cnt !== int'(exp_err) || obs_to_after !== exp_err || obs_done_cnt !== 1) begin
                n_bad++; $display("FAIL rnd_status[%0d]: got rst=%0d to=%b done=%0d want %0d %0d 1", k, obs_rst_cnt, obs_to_after, obs_done_cnt, exp_err, exp_err); end
            $display("txn rnd %0d: n=%0d mul=%0d result=%h exp=%h cycle=%0d err=%0d", k, n, mul, obs_result, exp_result, obs_cyc, exp_err);
        end
        noise_en = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        callee_ready = 1'b0; noise_en = 1'b0; op_mul = 1'b0; cidx = 0; cwait = 0;
        set_delays(0);
        test_reset();
        test_add_fold();
        test_mul_overflow();
        test_zero_iters();
        test_timeout();
        test_slow_boundary();
        test_reset_mid_op();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/std_invoke.md
Name: std_invoke

Overview:
- Initiator-side controller for the valid/ready primitive library.
- Captures operands on `go`, drives `valid` and operands into a callee primitive, and waits for `ready`.
- Folds the callee result back as the next left operand for a programmed number of iterations, giving iterated add, multiply, and similar operations.
- Supervises each handshake with a timeout and resets a hung callee. Sits between control logic and any std_* functional unit.

Parameters:
- width, 32, operand/result bit width
- cnt_width, 8, bit width of iteration count
- timeout, 255, max cycles callee_valid may wait for callee_ready per iteration (must be >=1)

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- go  input  1  start request, sampled in IDLE only
- iters  input  cnt_width  iteration count, captured with go
- left_in  input  width  initial left operand, captured with go
- right_in  input  width  constant right operand, captured with go
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle completion pulse
- timed_out  output  1  sticky error flag
- result  output  width  final/partial result register
- callee_valid  output  1  request valid to callee
- callee_reset  output  1  reset to callee
- callee_left  output  width  left operand to callee
- callee_right  output  width  right operand to callee
- callee_ready  input  1  callee handshake response
- callee_out  input  width  callee data, valid when callee_ready=1

Behaviour:
- Reset, asynchronous while reset=0:
  - state=IDLE.
  - busy, done, timed_out, callee_valid, callee_reset = 0.
  - result, internal operand registers, remaining count, wait counter = 0.
- States: IDLE, ISSUE, GAP, DONE, ERR.
- IDLE:
  - On go=1: capture left_in into acc and result, right_in into rhs, iters into rem; clear timed_out; clear the wait counter.
  - If iters=0, go to DONE; result=left_in and callee_valid is never raised. Otherwise go to ISSUE.
- ISSUE:
  - callee_valid=1, callee_left=acc, callee_right=rhs.
  - If callee_ready=1 at a clock edge:
    - acc and result <= callee_out.
    - rem <= rem-1.
    - wait counter cleared.
    - Next state is DONE if rem=1, else GAP.
  - If callee_ready=0: wait counter increments. When it reaches timeout, go to ERR instead.
- GAP: one cycle with callee_valid=0, so each handshake is a distinct request. Always goes to ISSUE.
- DONE: done=1 for exactly one cycle, then IDLE.
- ERR:
  - callee_reset=1 for exactly one cycle, done=1, timed_out<=1.
  - result holds the last successfully sampled value. Next state is IDLE.
- Outputs in IDLE, GAP, DONE and ERR:
  - callee_valid=0.
  - callee_left/callee_right still drive acc/rhs; callees must not depend on them.
  - callee_reset=0 in every state except ERR.
- busy is a function of state.
- Latency with a callee that holds ready=1:
  - go sampled at edge 0.
  - ISSUE occupies cycles 1, 3, …, 2n-1.
  - done is high in cycle 2n for iters=n>=1, and in cycle 1 for iters=0.
- Arithmetic: result is exactly width bits. Overflow is the callee's responsibility and is truncated as the callee produces it; the block adds no extension.
- go while busy=1 is ignored, with no effect on captured operands.
- iters, left_in and right_in changing after capture have no effect.
- Max iterations 2^cnt_width-1.
- callee_ready asserted outside ISSUE is ignored.
- ready arriving in the same cycle the wait counter reaches timeout: ready wins, the data is sampled, and there is no error.
- timed_out stays high through IDLE until the next accepted go.
- reset asserted mid-operation aborts immediately to IDLE with all outputs at reset values. No done pulse is generated.

Test Plan:
- Add fold: callee=std_add, ready=1, left_in=5, right_in=3, iters=4, go at edge 0 -> callee_valid high in cycles 1,3,5,7; done high only in cycle 8; result=17; timed_out=0.
- Mul fold with overflow: callee=std_mul width=8, left_in=2, right_in=16, iters=2 -> result=0 (32, then 512 truncated to 8 bits); done in cycle 4.
- Zero iterations: iters=0, left_in=0xDEAD -> done in cycle 1; result=0xDEAD; callee_valid never asserted.
- Timeout:
  - Stimulus: timeout=10, callee_ready held 0, iters=3.
  - Required response: ERR entered after 10 ISSUE cycles; callee_reset and done both pulse for one cycle; timed_out=1; result=left_in.
  - Then a new go clears timed_out.
- Slow callee and boundary:
  - Stimulus: timeout=4, ready asserted on the 4th ISSUE cycle.
  - Required response: no error; data sampled.
  - In the same run, a go pulse while busy is ignored and result is unchanged.
- Reset mid-op: assert reset=0 during the second ISSUE of a 4-iteration run -> all outputs 0 asynchronously; no done pulse. After release, a fresh go completes normally.
